// File: rtl/simon_sequencer.sv
// Simon game sequence controller: grows, plays back and checks a random colour sequence.
// Optional SIMON_SPEEDUP_EN halves playback durations once the sequence reaches length 8.
module simon_sequencer #(
    parameter int MAX_LEN       = 32,
    parameter int ON_TICKS      = 30,
    parameter int OFF_TICKS     = 15,
    parameter int TIMEOUT_TICKS = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] rand_in,
    input  logic [1:0] player_num,
    input  logic       player_pressed,
    output logic       simon_turn,
    output logic [1:0] simon_num,
    output logic       simon_pressed,
    output logic       game_over,
    output logic       win,
    output logic [6:0] level
);

    localparam int IW   = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;
    localparam int TMX0 = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TMAX = (TMX0 > TIMEOUT_TICKS) ? TMX0 : TIMEOUT_TICKS;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_APPEND, S_PLAY_ON, S_PLAY_OFF, S_WAIT_IN, S_GAME_OVER, S_WIN
    } state_t;

    state_t        state;
    logic [1:0]    mem [MAX_LEN];
    logic [6:0]    len;
    logic [IW-1:0] idx;
    logic [TW-1:0] timer;
    logic [TW-1:0] on_dur;
    logic [TW-1:0] off_dur;
    logic          last_step;

`ifdef SIMON_SPEEDUP_EN
    localparam int ON_FAST  = (ON_TICKS / 2 < 1) ? 1 : ON_TICKS / 2;
    localparam int OFF_FAST = (OFF_TICKS / 2 < 1) ? 1 : OFF_TICKS / 2;
    assign on_dur  = (len >= 7'd8) ? TW'(ON_FAST)  : TW'(ON_TICKS);
    assign off_dur = (len >= 7'd8) ? TW'(OFF_FAST) : TW'(OFF_TICKS);
`else
    assign on_dur  = TW'(ON_TICKS);
    assign off_dur = TW'(OFF_TICKS);
`endif

    assign last_step = (7'(idx) + 7'd1 == len);

    // Sequence storage is deliberately left uncleared; len alone marks valid entries.
    always_ff @(posedge clk) begin
        if (state == S_APPEND)
            mem[len[IW-1:0]] <= rand_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            len   <= '0;
            idx   <= '0;
            timer <= '0;
        end else begin
            case (state)
                S_IDLE, S_GAME_OVER, S_WIN: begin
                    if (start) begin
                        len   <= '0;
                        state <= S_APPEND;
                    end
                end
                S_APPEND: begin
                    len   <= len + 7'd1;
                    idx   <= '0;
                    timer <= '0;
                    state <= S_PLAY_ON;
                end
                S_PLAY_ON: begin
                    if (timer == on_dur - TW'(1)) begin
                        timer <= '0;
                        state <= S_PLAY_OFF;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_PLAY_OFF: begin
                    if (timer == off_dur - TW'(1)) begin
                        timer <= '0;
                        if (last_step) begin
                            idx   <= '0;
                            state <= S_WAIT_IN;
                        end else begin
                            idx   <= idx + IW'(1);
                            state <= S_PLAY_ON;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_WAIT_IN: begin
                    // A press on the final tick wins over the timeout.
                    if (player_pressed) begin
                        if (player_num != mem[idx]) begin
                            state <= S_GAME_OVER;
                        end else if (!last_step) begin
                            idx   <= idx + IW'(1);
                            timer <= '0;
                        end else if (len < 7'(MAX_LEN)) begin
                            state <= S_APPEND;
                        end else begin
                            state <= S_WIN;
                        end
                    end else if (timer == TW'(TIMEOUT_TICKS - 1)) begin
                        state <= S_GAME_OVER;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign simon_turn    = (state == S_APPEND) || (state == S_PLAY_ON) || (state == S_PLAY_OFF);
    assign simon_pressed = (state == S_PLAY_ON);
    assign game_over     = (state == S_GAME_OVER);
    assign win           = (state == S_WIN);
    assign level         = len;
    // APPEND also shows 0 so a not-yet-written entry never leaks onto the bus.
    assign simon_num     = (state == S_IDLE || state == S_APPEND) ? 2'd0 : mem[idx];

endmodule
